// File: rtl/noc_local_inject_arbiter.sv
// Packet-atomic round-robin arbiter sharing one router LOCAL input port
// among NREQ flit sources under the router credit handshake.
module noc_local_inject_arbiter #(
   parameter int NREQ     = 4,
   parameter int TAM_FLIT = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_i,
   input  logic [NREQ-1:0]          valid_i,
   input  logic [NREQ*TAM_FLIT-1:0] flit_i,
   output logic [NREQ-1:0]          ack_o,
   output logic [NREQ-1:0]          grant_o,
   output logic                     rx_o,
   output logic [TAM_FLIT-1:0]      data_o,
   input  logic                     credit_i,
   output logic                     busy_o
);

   localparam int PW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} state_t;

   state_t              state, state_nxt;
   logic [NREQ-1:0]     grant_nxt;
   logic [PW-1:0]       ptr, ptr_nxt, gidx, pick;
   logic                found;
   logic [TAM_FLIT-1:0] cnt, cnt_nxt, flit;
   logic                xfer;
   int                  idx;

   // grant_o is one-hot, so a plain priority encode yields the owner index
   always_comb begin
      gidx = '0;
      for (int k = 0; k < NREQ; k++)
         if (grant_o[k]) gidx = PW'(k);
   end

   assign flit   = flit_i[int'(gidx)*TAM_FLIT +: TAM_FLIT];
   assign busy_o = (state != IDLE);
   assign rx_o   = busy_o && valid_i[gidx];
   assign data_o = busy_o ? flit : '0;
   assign xfer   = rx_o && credit_i;
   assign ack_o  = xfer ? grant_o : '0;

   // first pending requester at or after ptr, in circular order
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_i[idx]) begin
            found = 1'b1;
            pick  = PW'(idx);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant_o;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            grant_nxt = '0;
            if (found) begin
               grant_nxt = NREQ'(1) << pick;
               ptr_nxt   = (pick == PW'(NREQ-1)) ? '0 : pick + 1'b1;
               state_nxt = HEADER;
            end
         end
         HEADER: begin
            if (xfer) state_nxt = SIZE;
         end
         SIZE: begin
            if (xfer) begin
               cnt_nxt = flit;
               if (flit == '0) begin
                  state_nxt = IDLE;
                  grant_nxt = '0;
               end else begin
                  state_nxt = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (xfer) begin
               cnt_nxt = cnt - 1'b1;
               if (cnt == TAM_FLIT'(1)) begin
                  state_nxt = IDLE;
                  grant_nxt = '0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         grant_o <= '0;
         ptr     <= '0;
         cnt     <= '0;
      end else begin
         state   <= state_nxt;
         grant_o <= grant_nxt;
         ptr     <= ptr_nxt;
         cnt     <= cnt_nxt;
      end
   end

endmodule
